// File: rtl/sharpen_stream_if.sv
// Stream bundle for sharpen_stream: pixel input, sharpened output, mode and status.
// master = upstream/sink side (the environment), slave = the sharpen block.
interface sharpen_stream_if #(
  parameter int PIX_W = 8,
  parameter int LANES = 4
);
  localparam int DW = LANES * PIX_W;

  logic [1:0]    cfg_mode;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;

  modport master (
    output cfg_mode, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last, busy
  );

  modport slave (
    input  cfg_mode, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last, busy
  );
endinterface

// File: rtl/sharpen_stream.sv
// Streaming 3x3 sharpen filter over packed pixel words, one output row behind input,
// with two line buffers and a final FLUSH pass that emits the last row.
module sharpen_stream #(
  parameter int PIX_W = 8,
  parameter int LANES = 4,
  parameter int WORDS = 16,
  parameter int ROWS  = 16
) (
  input  logic            clk,
  input  logic            reset,
  sharpen_stream_if.slave bus
);
  localparam int DW = LANES * PIX_W;
  localparam int SW = PIX_W + 5;
  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int RW = $clog2(ROWS);
  localparam logic [CW-1:0] COL_LAST = CW'(WORDS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

  state_t        state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [1:0]    mode_q;
  logic [DW-1:0] out_data_p0;
  logic          vld_p0;
  logic          last_p0;

  logic [DW-1:0] prev_buf [WORDS];
  logic [DW-1:0] cur_buf  [WORDS];

  function automatic logic signed [SW-1:0] ext(input logic [PIX_W-1:0] p);
    return $signed({5'b00000, p});
  endfunction

  function automatic logic [PIX_W-1:0] clamp_pix(input logic signed [SW-1:0] v);
    if (v[SW-1])
      return '0;
    if (|v[SW-2:PIX_W])
      return '1;
    return v[PIX_W-1:0];
  endfunction

  function automatic logic [PIX_W-1:0] lane_of(input logic [DW-1:0] w, input int idx);
    return w[idx*PIX_W +: PIX_W];
  endfunction

  // Missing left/right neighbours are replaced by lane-index clamping; missing rows
  // arrive already substituted by the caller.
  function automatic logic [DW-1:0] sharpen_word(input logic [1:0]    mode,
                                                 input logic [DW-1:0] u_w,
                                                 input logic [DW-1:0] c_w,
                                                 input logic [DW-1:0] d_w);
    logic [DW-1:0]          res;
    logic signed [SW-1:0]   c, n4, nd, acc;
    int                     lf, rt;
    res = '0;
    for (int i = 0; i < LANES; i++) begin
      lf = (i == 0) ? 0 : i - 1;
      rt = (i == LANES - 1) ? i : i + 1;
      c  = ext(lane_of(c_w, i));
      n4 = ext(lane_of(u_w, i)) + ext(lane_of(d_w, i)) +
           ext(lane_of(c_w, lf)) + ext(lane_of(c_w, rt));
      nd = ext(lane_of(u_w, lf)) + ext(lane_of(u_w, rt)) +
           ext(lane_of(d_w, lf)) + ext(lane_of(d_w, rt));
      case (mode)
        2'b01:   acc = (c <<< 2) + c - n4;
        2'b10:   acc = (c <<< 3) + c - n4 - nd;
        default: acc = c;
      endcase
      res[i*PIX_W +: PIX_W] = clamp_pix(acc);
    end
    return res;
  endfunction

  logic          slot_free, in_ready_w, in_fire, run_fire, flush_load, out_fire;
  logic [DW-1:0] ctr_w, prev_w, up_w, dn_w, result_w;

  assign slot_free  = !vld_p0 || bus.out_ready;
  assign in_ready_w = (state != FLUSH) && slot_free;
  assign in_fire    = bus.in_valid && in_ready_w;
  assign run_fire   = in_fire && (state == RUN);
  assign flush_load = (state == FLUSH) && !last_p0 && slot_free;
  assign out_fire   = vld_p0 && bus.out_ready;

  // While row 1 is arriving the centre is output row 0, which has no row above.
  assign ctr_w    = cur_buf[col];
  assign prev_w   = prev_buf[col];
  assign up_w     = (state == RUN && row == ROW_ONE) ? ctr_w : prev_w;
  assign dn_w     = (state == FLUSH) ? ctr_w : bus.in_data;
  assign result_w = sharpen_word(mode_q, up_w, ctr_w, dn_w);

  // ---- stage p0: control FSM and registered output word ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FILL;
      row         <= '0;
      col         <= '0;
      mode_q      <= 2'b00;
      vld_p0      <= 1'b0;
      last_p0     <= 1'b0;
      out_data_p0 <= '0;
    end else begin
      if (out_fire) begin
        vld_p0  <= 1'b0;
        last_p0 <= 1'b0;
      end
      if (run_fire || flush_load) begin
        vld_p0      <= 1'b1;
        out_data_p0 <= result_w;
        last_p0     <= flush_load && (col == COL_LAST);
      end
      case (state)
        FILL: begin
          if (in_fire) begin
            if (col == '0)
              mode_q <= bus.cfg_mode;
            if (col == COL_LAST) begin
              col   <= '0;
              row   <= ROW_ONE;
              state <= RUN;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        RUN: begin
          if (in_fire) begin
            if (col == COL_LAST) begin
              col <= '0;
              if (row == ROW_LAST)
                state <= FLUSH;
              else
                row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        FLUSH: begin
          if (flush_load)
            col <= (col == COL_LAST) ? '0 : col + 1'b1;
          if (out_fire && last_p0) begin
            state <= FILL;
            row   <= '0;
            col   <= '0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  // ---- line buffers (data only, never reset) ----
  always_ff @(posedge clk) begin
    if (in_fire && state == FILL) begin
      cur_buf[col] <= bus.in_data;
    end else if (run_fire) begin
      prev_buf[col] <= ctr_w;
      cur_buf[col]  <= bus.in_data;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_data  = out_data_p0;
  assign bus.out_valid = vld_p0;
  assign bus.out_last  = last_p0;
  assign bus.busy      = !(state == FILL && row == '0 && col == '0);
endmodule

// File: tb/tb_sharpen_stream.sv
// Directed bench for sharpen_stream: flat frames, spot/hole frames, backpressure,
// reset mid-frame and mid-flush, and per-frame mode latching.
module tb_sharpen_stream;
  localparam int PW = 8;
  localparam int LN = 4;
  localparam int WD = 16;
  localparam int RS = 16;
  localparam int NW = WD * RS;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sharpen_stream_if #(.PIX_W(PW), .LANES(LN)) bus ();

  sharpen_stream #(.PIX_W(PW), .LANES(LN), .WORDS(WD), .ROWS(RS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] frame_in [NW];
  logic [31:0] got_d    [NW];
  logic        got_l    [NW];
  int          got_n, flush_rdy, first_out_in;
  logic        first_rdy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fill_const(input logic [7:0] v);
    for (int i = 0; i < NW; i++) frame_in[i] = {4{v}};
  endtask

  task automatic fill_rand();
    for (int i = 0; i < NW; i++) frame_in[i] = $urandom;
  endtask

  task automatic set_pix(input int r, input int w, input int l, input logic [7:0] v);
    logic [31:0] t;
    t = frame_in[r*WD + w];
    t[l*8 +: 8] = v;
    frame_in[r*WD + w] = t;
  endtask

  // Reference image access with edge replication in rows and within a word.
  function automatic int pix(input int r, input int w, input int l);
    logic [31:0] t;
    int rr, ll;
    rr = (r < 0) ? 0 : (r > RS - 1) ? RS - 1 : r;
    ll = (l < 0) ? 0 : (l > LN - 1) ? LN - 1 : l;
    t = frame_in[rr*WD + w];
    return int'(t[ll*8 +: 8]);
  endfunction

  function automatic logic [31:0] model_word(input int mode, input int r, input int w);
    logic [31:0] res;
    int c, s4, sd, v;
    res = '0;
    for (int l = 0; l < LN; l++) begin
      c  = pix(r, w, l);
      s4 = pix(r-1, w, l) + pix(r+1, w, l) + pix(r, w, l-1) + pix(r, w, l+1);
      sd = pix(r-1, w, l-1) + pix(r-1, w, l+1) + pix(r+1, w, l-1) + pix(r+1, w, l+1);
      if (mode == 1)      v = 5*c - s4;
      else if (mode == 2) v = 9*c - s4 - sd;
      else                v = c;
      if (v < 0)   v = 0;
      if (v > 255) v = 255;
      res[l*8 +: 8] = 8'(v);
    end
    return res;
  endfunction

  // Called at a falling edge; returns at a falling edge.
  task automatic run_frame(input logic [1:0] mode, input logic [1:0] mode2, input int switch_at,
                           input int n_in, input bit rnd_bp, input bit expect_out);
    int in_idx, cyc;
    in_idx = 0; cyc = 0; got_n = 0; flush_rdy = 0; first_out_in = -1; first_rdy = 1'b0;
    while ((expect_out ? (got_n < NW) : (in_idx < n_in)) && cyc < 5000) begin
      bus.cfg_mode  = (in_idx >= switch_at) ? mode2 : mode;
      bus.in_valid  = (in_idx < n_in);
      bus.in_data   = (in_idx < n_in) ? frame_in[in_idx] : '0;
      bus.out_ready = rnd_bp ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (cyc == 0) first_rdy = bus.in_ready;
      if (first_out_in < 0 && bus.out_valid) first_out_in = in_idx;
      if (in_idx == NW && bus.in_ready) flush_rdy++;
      if (bus.out_valid && bus.out_ready && got_n < NW) begin
        got_d[got_n] = bus.out_data;
        got_l[got_n] = bus.out_last;
        got_n++;
      end
      if (bus.in_valid && bus.in_ready) in_idx++;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    bus.in_valid = 1'b0;
    if (expect_out) chk("frame word count", got_n, NW);
    else            chk("input accept count", in_idx, n_in);
  endtask

  task automatic check_frame(input int mode, input string tag);
    for (int i = 0; i < NW; i++) begin
      chk($sformatf("%s data w%0d", tag, i), got_d[i], model_word(mode, i / WD, i % WD));
      chk($sformatf("%s last w%0d", tag, i), 32'(got_l[i]), 32'(i == NW - 1));
    end
  endtask

  task automatic check_flat(input string tag);
    int nl, lp;
    nl = 0; lp = -1;
    for (int i = 0; i < NW; i++) begin
      chk($sformatf("%s data w%0d", tag, i), got_d[i], 32'h80808080);
      if (got_l[i]) begin nl++; lp = i; end
    end
    chk({tag, " last count"}, nl, 1);
    chk({tag, " last pos"}, lp, NW - 1);
  endtask

  initial begin
    reset         = 1'b1;
    bus.cfg_mode  = 2'b00;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset out_valid", 32'(bus.out_valid), 0);
    chk("reset out_last", 32'(bus.out_last), 0);
    chk("reset out_data", bus.out_data, 0);
    chk("reset busy", 32'(bus.busy), 0);
    chk("reset in_ready", 32'(bus.in_ready), 1);
    @(negedge clk);

    fill_const(8'h80);
    run_frame(2'b01, 2'b01, NW, NW, 1'b0, 1'b1);
    check_flat("flat01");
    #1;
    chk("idle busy after frame", 32'(bus.busy), 0);
    chk("idle in_ready after frame", 32'(bus.in_ready), 1);
    @(negedge clk);
    run_frame(2'b10, 2'b10, NW, NW, 1'b1, 1'b1);
    check_flat("flat10");

    fill_const(8'h00);
    set_pix(5, 3, 1, 8'h40);
    run_frame(2'b01, 2'b01, NW, NW, 1'b0, 1'b1);
    chk("spot centre", got_d[5*WD + 3], 32'h0000FF00);
    chk("spot up", got_d[4*WD + 3], 32'h00000000);
    chk("spot down", got_d[6*WD + 3], 32'h00000000);
    check_frame(1, "spot01");

    fill_const(8'hFF);
    set_pix(5, 3, 1, 8'h00);
    run_frame(2'b01, 2'b01, NW, NW, 1'b0, 1'b1);
    chk("hole01 centre", got_d[5*WD + 3], 32'hFFFF00FF);
    check_frame(1, "hole01");
    run_frame(2'b10, 2'b10, NW, NW, 1'b1, 1'b1);
    chk("hole10 centre", got_d[5*WD + 3], 32'hFFFF00FF);
    check_frame(2, "hole10");

    fill_const(8'h00);
    set_pix(5, 3, 1, 8'hFF);
    run_frame(2'b10, 2'b10, NW, NW, 1'b0, 1'b1);
    chk("peak10 centre", got_d[5*WD + 3], 32'h0000FF00);
    check_frame(2, "peak10");

    fill_rand();
    run_frame(2'b11, 2'b11, NW, NW, 1'b1, 1'b1);
    check_frame(3, "bp11 f1");
    chk("bp11 f1 in_ready in flush", flush_rdy, 0);
    fill_rand();
    run_frame(2'b11, 2'b11, NW, NW, 1'b1, 1'b1);
    chk("bp11 f2 first accept", 32'(first_rdy), 1);
    check_frame(3, "bp11 f2");
    chk("bp11 f2 in_ready in flush", flush_rdy, 0);

    fill_rand();
    run_frame(2'b01, 2'b01, NW, 9*WD + 7, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midreset out_valid", 32'(bus.out_valid), 0);
    chk("midreset busy", 32'(bus.busy), 0);
    @(negedge clk);
    fill_rand();
    run_frame(2'b01, 2'b01, NW, NW, 1'b1, 1'b1);
    chk("fresh first output", first_out_in, WD + 1);
    check_frame(1, "fresh01");

    fill_rand();
    run_frame(2'b00, 2'b00, NW, NW, 1'b0, 1'b0);
    bus.out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("flushreset out_valid c%0d", k), 32'(bus.out_valid), 0);
      @(negedge clk);
    end

    fill_rand();
    run_frame(2'b01, 2'b00, 100, NW, 1'b1, 1'b1);
    check_frame(1, "switch f1");
    fill_rand();
    run_frame(2'b00, 2'b01, 100, NW, 1'b1, 1'b1);
    check_frame(0, "switch f2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
